// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_RUN,
        S_ERR
    } state_t;

    localparam int HDR_BYTES  = 2;  // little-endian 16-bit word count
    localparam int WORD_BYTES = 4;  // bytes per instruction word

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler. The first three bytes of a word are
// held in a shift register; the fourth byte is merged combinationally so
// the assembled word and its valid pulse appear in the same cycle the last
// byte is accepted.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int BW = $clog2(WORD_BYTES);
    localparam int LW = 8 * (WORD_BYTES - 1);

    logic [BW-1:0] byte_idx;
    logic [LW-1:0] low_bytes;

    // Shift new bytes in from the top so byte 0 ends up in the lowest lane.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx  <= '0;
            low_bytes <= '0;
        end else if (byte_en) begin
            byte_idx  <= byte_idx + BW'(1);
            low_bytes <= {in_byte, low_bytes[LW-1:8]};
        end
    end

    assign word       = {in_byte, low_bytes};
    assign word_valid = byte_en && (byte_idx == BW'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a 2-byte word-count header, assembles
// little-endian instruction words, writes them to instruction memory at
// consecutive addresses and releases the core once the last word lands.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        error
);

    localparam int IW = $clog2(DEPTH_WORDS + 1);

    state_t        state, state_nxt;
    logic [7:0]    cnt_lo;
    logic [IW-1:0] cnt_words;
    logic [IW-1:0] word_idx;
    logic [15:0]   hdr_cnt;
    logic          hdr_bad;
    logic          accept;
    logic          pk_clear;
    logic          pk_en;
    logic [31:0]   word;
    logic          word_valid;
    logic          last_word;

    // Loading states take bytes unconditionally; the reset term keeps
    // in_ready low during the reset cycle itself.
    assign in_ready  = !reset && (state == S_CNT_LO || state == S_CNT_HI || state == S_DATA);
    assign accept    = in_valid && in_ready;
    assign hdr_cnt   = {in_byte, cnt_lo};
    assign hdr_bad   = (hdr_cnt == 16'd0) || (hdr_cnt > 16'(DEPTH_WORDS));
    assign pk_clear  = accept && (state == S_CNT_HI);
    assign pk_en     = accept && (state == S_DATA);
    assign last_word = word_valid && ((word_idx + IW'(1)) == cnt_words);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_en    (pk_en),
        .in_byte    (in_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_CNT_LO;
        else       state <= state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt  = state;
        core_reset = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_CNT_LO: if (accept) state_nxt = S_CNT_HI;
            S_CNT_HI: if (accept) state_nxt = hdr_bad ? S_ERR : S_DATA;
            S_DATA:   if (last_word) state_nxt = S_RUN;
            S_RUN: begin
                core_reset = 1'b0;
                done       = 1'b1;
            end
            S_ERR:    error = 1'b1;
            default:  state_nxt = S_CNT_LO;
        endcase
    end

    // Header capture and word index bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_lo    <= '0;
            cnt_words <= '0;
            word_idx  <= '0;
        end else begin
            if (accept && state == S_CNT_LO) cnt_lo <= in_byte;
            if (pk_clear) begin
                cnt_words <= IW'(hdr_cnt);
                word_idx  <= '0;
            end else if (word_valid) begin
                word_idx  <= word_idx + IW'(1);
            end
        end
    end

    // Registered write port; address and data hold between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
        end else begin
            imem_we <= word_valid;
            if (word_valid) begin
                imem_addr  <= BASE_ADDR + {{(30-IW){1'b0}}, word_idx, 2'b00};
                imem_wdata <= word;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: byte-stream level reference model,
// per-cycle output comparison and directed literal checks.
module tb_prog_loader;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    prog_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-stream semantics) ----------------
    int          m_nacc;
    int          m_cnt;
    logic [7:0]  m_lo;
    logic [31:0] m_w;
    logic        m_we, m_done, m_err;
    logic [31:0] m_addr, m_data;
    bit          chk_en = 0;

    initial begin
        int k;
        m_nacc = 0; m_cnt = 0; m_lo = 0; m_w = 0;
        m_we = 0; m_done = 0; m_err = 0; m_addr = BASE; m_data = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_nacc = 0; m_we = 0; m_done = 0; m_err = 0;
                m_addr = BASE; m_data = 0;
                chk_en = 1;
            end else begin
                m_we = 0;
                if (in_valid && !m_done && !m_err) begin
                    if (m_nacc == 0) begin
                        m_lo = in_byte;
                    end else if (m_nacc == 1) begin
                        m_cnt = int'({in_byte, m_lo});
                        if (m_cnt == 0 || m_cnt > DEPTH) m_err = 1;
                    end else begin
                        k = m_nacc - 2;
                        m_w[(k % 4) * 8 +: 8] = in_byte;
                        if (k % 4 == 3) begin
                            m_we   = 1;
                            m_addr = BASE + 32'(4 * (k / 4));
                            m_data = m_w;
                            if (k / 4 + 1 == m_cnt) m_done = 1;
                        end
                    end
                    m_nacc++;
                end
            end
        end
    end

    // ---------------- per-cycle compare + write capture ----------------
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready",   {31'd0, in_ready},   {31'd0, !reset && !m_done && !m_err});
                chk("imem_we",    {31'd0, imem_we},    {31'd0, m_we});
                chk("imem_addr",  imem_addr,           m_addr);
                chk("imem_wdata", imem_wdata,          m_data);
                chk("core_reset", {31'd0, core_reset}, {31'd0, !m_done});
                chk("done",       {31'd0, done},       {31'd0, m_done});
                chk("error",      {31'd0, error},      {31'd0, m_err});
                if (imem_we) begin
                    wa.push_back(imem_addr);
                    wd.push_back(imem_wdata);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            in_byte = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic put(input logic [7:0] b, input int gmax);
        int g;
        g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
        in_valid = 1'b0;
        idle(g);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        idle(2);
        reset    = 1'b0;
    endtask

    task automatic put_hdr(input int cnt, input int gmax);
        put(8'(cnt), gmax);
        put(8'(cnt >> 8), gmax);
    endtask

    // ---------------- test sequence ----------------
    logic [7:0]  bytes[$];
    logic [31:0] q1a[$];
    logic [31:0] q1d[$];
    logic [31:0] exp_w;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
        idle(2);
        reset = 1'b0;
        idle(1);
        chk("rst_addr",  imem_addr, BASE);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_core",  {31'd0, core_reset}, 32'd1);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // Two-word directed load.
        wa.delete(); wd.delete();
        put(8'h02, 0); put(8'h00, 0);
        put(8'h13, 0); put(8'h00, 0); put(8'ha0, 0); put(8'h00, 0);
        put(8'h93, 0); put(8'h00, 0); put(8'h50, 0); put(8'h00, 0);
        chk("t1_we2",   {31'd0, imem_we}, 32'd1);
        chk("t1_done",  {31'd0, done}, 32'd1);
        chk("t1_core",  {31'd0, core_reset}, 32'd0);
        idle(1);
        chk("t1_nwr",   32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("t1_a0", wa[0], 32'h0);
            chk("t1_d0", wd[0], 32'h00a00013);
            chk("t1_a1", wa[1], 32'h4);
            chk("t1_d1", wd[1], 32'h00500093);
        end

        // Bytes after done are ignored.
        for (int i = 0; i < 8; i++) put(8'($urandom), 0);
        idle(1);
        chk("t7_nwr",  32'(wa.size()), 32'd2);
        chk("t7_done", {31'd0, done}, 32'd1);

        // Zero count header.
        do_reset(); wa.delete(); wd.delete();
        put(8'h00, 0); put(8'h00, 0);
        chk("t2_err",   {31'd0, error}, 32'd1);
        chk("t2_ready", {31'd0, in_ready}, 32'd0);
        chk("t2_core",  {31'd0, core_reset}, 32'd1);
        put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h44, 0);
        idle(2);
        chk("t2_nwr",   32'(wa.size()), 32'd0);

        // Count one past capacity.
        do_reset();
        put(8'h41, 0); put(8'h00, 0);
        chk("t3_err", {31'd0, error}, 32'd1);

        // Full-capacity load.
        do_reset(); wa.delete(); wd.delete(); bytes.delete();
        put(8'h40, 0); put(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            bytes.push_back(8'($urandom));
            put(bytes[i], 0);
        end
        idle(2);
        chk("t4_nwr",  32'(wa.size()), 32'd64);
        chk("t4_done", {31'd0, done}, 32'd1);
        if (wa.size() == 64) begin
            chk("t4_last_addr", wa[63], 32'hfc);
            exp_w = {bytes[255], bytes[254], bytes[253], bytes[252]};
            chk("t4_last_data", wd[63], exp_w);
        end

        // Three-word load, gap-free then with random gaps.
        bytes.delete();
        for (int i = 0; i < 12; i++) bytes.push_back(8'($urandom));
        do_reset(); wa.delete(); wd.delete();
        put_hdr(3, 0);
        foreach (bytes[i]) put(bytes[i], 0);
        idle(2);
        q1a = wa; q1d = wd;
        do_reset(); wa.delete(); wd.delete();
        put_hdr(3, 5);
        foreach (bytes[i]) put(bytes[i], 5);
        idle(2);
        chk("t5_nwr", 32'(wa.size()), 32'd3);
        if (wa.size() == 3 && q1a.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                exp_w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
                chk("t5_addr",     wa[i], 32'(4 * i));
                chk("t5_data",     wd[i], exp_w);
                chk("t5_same_a",   wa[i], q1a[i]);
                chk("t5_same_d",   wd[i], q1d[i]);
            end
        end

        // Reset mid-load, then a fresh one-word program.
        do_reset(); wa.delete(); wd.delete();
        put_hdr(2, 0);
        for (int i = 0; i < 6; i++) put(8'($urandom), 0);
        wa.delete(); wd.delete();
        do_reset();
        put(8'h01, 0); put(8'h00, 0);
        put(8'hef, 0); put(8'hbe, 0); put(8'had, 0); put(8'hde, 0);
        idle(2);
        chk("t6_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("t6_addr", wa[0], 32'h0);
            chk("t6_data", wd[0], 32'hdeadbeef);
        end
        chk("t6_done", {31'd0, done}, 32'd1);

        // Random loads: legal and illegal counts, gaps, occasional aborts.
        for (int it = 0; it < 20; it++) begin
            int cnt, nb;
            do_reset();
            case ($urandom_range(5, 0))
                0:       cnt = 0;
                1:       cnt = DEPTH + 1 + int'($urandom_range(300, 0));
                default: cnt = int'($urandom_range(6, 1));
            endcase
            put_hdr(cnt, 2);
            nb = 4 * cnt + 4;
            if ($urandom_range(3, 0) == 0) nb = int'($urandom_range(4 * cnt + 1, 0));
            for (int i = 0; i < nb && i < 40; i++) put(8'($urandom), 2);
            idle(3);
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
